// File: rtl/fat32_dir_entry_scanner.sv
// Walks a streamed 512-byte FAT32 directory sector and locates the 8.3 short entry matching
// TARGET_NAME, reporting its first cluster, file size and entry index.
module fat32_dir_entry_scanner #(
    parameter logic [87:0] TARGET_NAME = "DATA    BIN",
    parameter logic        MATCH_DIR   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        busy,
    output logic        found,
    output logic        not_found,
    output logic        next_sector,
    output logic [31:0] first_cluster,
    output logic [31:0] file_size,
    output logic [15:0] entry_index
);

    typedef enum logic [1:0] {StIdle, StScan, StFound, StEnd} state_e;

    state_e      state_q, state_d;
    logic [8:0]  offset_q, offset_d;
    logic        match_q, match_d;
    logic        skip_q, skip_d;
    logic [15:0] clus_hi_q, clus_hi_d;
    logic [15:0] clus_lo_q, clus_lo_d;
    logic [31:0] size_q, size_d;
    logic [31:0] first_cluster_q, first_cluster_d;
    logic [31:0] file_size_q, file_size_d;
    logic [15:0] entry_index_q, entry_index_d;
    logic        next_sector_q, next_sector_d;

    logic [4:0]  slot_off;
    logic [7:0]  in_byte;
    logic [7:0]  tgt_byte;
    logic        byte_eq;

    function automatic logic [7:0] upcase(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    endfunction

    assign slot_off = offset_q[4:0];

    always_comb begin
        state_d         = state_q;
        offset_d        = offset_q;
        match_d         = match_q;
        skip_d          = skip_q;
        clus_hi_d       = clus_hi_q;
        clus_lo_d       = clus_lo_q;
        size_d          = size_q;
        first_cluster_d = first_cluster_q;
        file_size_d     = file_size_q;
        entry_index_d   = entry_index_q;
        next_sector_d   = 1'b0;

        // A leading 0x05 stands for a real 0xE5 first character.
        in_byte = (slot_off == 5'd0 && byte_data == 8'h05) ? 8'hE5 : byte_data;
        tgt_byte = 8'h00;
        for (int i = 0; i < 11; i++) begin
            if (slot_off == 5'(i)) tgt_byte = TARGET_NAME[87 - 8*i -: 8];
        end
        byte_eq = (upcase(in_byte) == upcase(tgt_byte));

        if (start) begin
            state_d         = StScan;
            offset_d        = '0;
            match_d         = 1'b0;
            skip_d          = 1'b0;
            first_cluster_d = '0;
            file_size_d     = '0;
            entry_index_d   = '0;
        end else if (state_q == StScan && byte_valid) begin
            offset_d = offset_q + 9'd1;
            if (slot_off < 5'd11) match_d = ((slot_off == 5'd0) ? 1'b1 : match_q) & byte_eq;
            case (slot_off)
                5'd0: begin
                    skip_d = (byte_data == 8'hE5);
                    if (byte_data == 8'h00) state_d = StEnd;
                end
                5'd11: begin
                    if (byte_data == 8'h0F || byte_data[3] || (byte_data[4] && !MATCH_DIR))
                        skip_d = 1'b1;
                end
                5'd20: clus_hi_d[7:0]  = byte_data;
                5'd21: clus_hi_d[15:8] = byte_data;
                5'd26: clus_lo_d[7:0]  = byte_data;
                5'd27: clus_lo_d[15:8] = byte_data;
                5'd28: size_d[7:0]     = byte_data;
                5'd29: size_d[15:8]    = byte_data;
                5'd30: size_d[23:16]   = byte_data;
                5'd31: begin
                    if (!skip_q && match_q) begin
                        state_d         = StFound;
                        first_cluster_d = {4'b0, clus_hi_q[11:0], clus_lo_q};
                        file_size_d     = {byte_data, size_q[23:0]};
                    end else begin
                        entry_index_d = entry_index_q + 16'd1;
                        if (offset_q == 9'd511) next_sector_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            offset_q        <= '0;
            match_q         <= 1'b0;
            skip_q          <= 1'b0;
            clus_hi_q       <= '0;
            clus_lo_q       <= '0;
            size_q          <= '0;
            first_cluster_q <= '0;
            file_size_q     <= '0;
            entry_index_q   <= '0;
            next_sector_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            offset_q        <= offset_d;
            match_q         <= match_d;
            skip_q          <= skip_d;
            clus_hi_q       <= clus_hi_d;
            clus_lo_q       <= clus_lo_d;
            size_q          <= size_d;
            first_cluster_q <= first_cluster_d;
            file_size_q     <= file_size_d;
            entry_index_q   <= entry_index_d;
            next_sector_q   <= next_sector_d;
        end
    end

    assign busy          = (state_q == StScan);
    assign found         = (state_q == StFound);
    assign not_found     = (state_q == StEnd);
    assign next_sector   = next_sector_q;
    assign first_cluster = first_cluster_q;
    assign file_size     = file_size_q;
    assign entry_index   = entry_index_q;

endmodule
